// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, memory-wait freeze, redirect flush, illegal-insn drain-and-halt.
// Optional HAZARD_PERF_CNT_EN adds registered stall/flush event counters (o_stall_cnt, o_flush_cnt).
//
// state     | meaning
// ----------+----------------------------------------------------------------
// RUN       | normal flow; hazards evaluated in priority mw > redirect > illegal > luh
// MEM_WAIT  | whole pipe frozen until dmem_ready, bounded by MEM_TIMEOUT
// DRAIN     | fetch frozen, bubbles into ID/EX while older work retires
// HALT      | everything frozen until reset; o_err holds the cause
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_id_valid,
    input  logic        i_id_insn_vld,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_rd_wren,
    input  logic        i_ex_is_load,
    input  logic        i_ex_redirect,
    input  logic        i_mem_req,
    input  logic        i_dmem_ready,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_halt,
    output logic [1:0]  o_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_MEM_TO  = 2'b10;

    // Limits clamp to the 8-bit counter range so a large parameter cannot wrap the compare.
    localparam int unsigned MEM_TO_CLAMP = (MEM_TIMEOUT > 255) ? 255 : MEM_TIMEOUT;
    localparam int unsigned DRAIN_CLAMP  = (DRAIN_CYCLES > 255) ? 255 : DRAIN_CYCLES;
    localparam logic [7:0]  MEM_TO_LIM   = 8'(MEM_TO_CLAMP);
    localparam logic [7:0]  DRAIN_LIM    = 8'(DRAIN_CLAMP);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] drain_cnt_q, drain_cnt_d;
    logic       halt_q, halt_d;
    logic [1:0] err_q, err_d;

    logic       luh, mw, illegal;
    logic [7:0] wait_inc, drain_inc;
    logic       pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic       if_id_flush_c, id_ex_flush_c;

    assign luh = i_ex_is_load & i_ex_rd_wren & (i_ex_rd != 5'd0) &
                 ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                  (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
    assign mw      = i_mem_req & ~i_dmem_ready;
    assign illegal = i_id_valid & ~i_id_insn_vld;

    assign wait_inc  = (wait_cnt_q  == 8'hFF) ? 8'hFF : wait_cnt_q  + 8'd1;
    assign drain_inc = (drain_cnt_q == 8'hFF) ? 8'hFF : drain_cnt_q + 8'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            drain_cnt_q <= 8'd0;
            halt_q      <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        halt_d        = halt_q;
        err_d         = err_q;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        id_ex_en_c    = 1'b0;
        ex_mem_en_c   = 1'b0;
        mem_wb_en_c   = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mw) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else if (i_ex_redirect) begin
                    pc_en_c       = 1'b1;
                    if_id_en_c    = 1'b1;
                    id_ex_en_c    = 1'b1;
                    ex_mem_en_c   = 1'b1;
                    mem_wb_en_c   = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (illegal || luh) begin
                    id_ex_en_c    = 1'b1;
                    ex_mem_en_c   = 1'b1;
                    mem_wb_en_c   = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (illegal) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 8'd1;
                    end
                end else begin
                    pc_en_c     = 1'b1;
                    if_id_en_c  = 1'b1;
                    id_ex_en_c  = 1'b1;
                    ex_mem_en_c = 1'b1;
                    mem_wb_en_c = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // Exit cycle skips hazard checks: EX and MEM advance together here.
                if (i_dmem_ready) begin
                    pc_en_c     = 1'b1;
                    if_id_en_c  = 1'b1;
                    id_ex_en_c  = 1'b1;
                    ex_mem_en_c = 1'b1;
                    mem_wb_en_c = 1'b1;
                    state_d     = ST_RUN;
                    wait_cnt_d  = 8'd0;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= MEM_TO_LIM) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                        err_d   = ERR_MEM_TO;
                    end
                end
            end

            ST_DRAIN: begin
                id_ex_flush_c = 1'b1;
                id_ex_en_c    = ~mw;
                ex_mem_en_c   = ~mw;
                mem_wb_en_c   = ~mw;
                if (!mw) begin
                    drain_cnt_d = drain_inc;
                    if (drain_inc >= DRAIN_LIM) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                        err_d   = ERR_ILLEGAL;
                    end
                end
            end

            ST_HALT: begin
                halt_d = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Strobes are forced low while reset is asserted, independent of inputs.
    assign o_pc_en       = i_rst_n & pc_en_c;
    assign o_if_id_en    = i_rst_n & if_id_en_c;
    assign o_id_ex_en    = i_rst_n & id_ex_en_c;
    assign o_ex_mem_en   = i_rst_n & ex_mem_en_c;
    assign o_mem_wb_en   = i_rst_n & mem_wb_en_c;
    assign o_if_id_flush = i_rst_n & if_id_flush_c;
    assign o_id_ex_flush = i_rst_n & id_ex_flush_c;
    assign o_halt        = halt_q;
    assign o_err         = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // IF/ID flush is only ever raised by a redirect, so it doubles as the flush event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if ((state_q != ST_HALT) && !pc_en_c && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_flush_c && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions, negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int MEM_TO = 16;
    localparam int DRAIN  = 3;

    typedef struct packed {
        logic       rst_n;
        logic       id_valid;
        logic       id_insn_vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] ex_rd;
        logic       ex_rd_wren;
        logic       ex_is_load;
        logic       ex_redirect;
        logic       mem_req;
        logic       dmem_ready;
    } stim_t;

    typedef struct {
        logic [9:0]  v;
        logic [31:0] sc;
        logic [31:0] fc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    stim_t s_cur;
    logic o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
    logic o_if_id_flush, o_id_ex_flush, o_halt;
    logic [1:0] o_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clk         (clk),
        .i_rst_n       (s_cur.rst_n),
        .i_id_valid    (s_cur.id_valid),
        .i_id_insn_vld (s_cur.id_insn_vld),
        .i_id_rs1      (s_cur.rs1),
        .i_id_rs2      (s_cur.rs2),
        .i_id_rs1_used (s_cur.rs1_used),
        .i_id_rs2_used (s_cur.rs2_used),
        .i_ex_rd       (s_cur.ex_rd),
        .i_ex_rd_wren  (s_cur.ex_rd_wren),
        .i_ex_is_load  (s_cur.ex_is_load),
        .i_ex_redirect (s_cur.ex_redirect),
        .i_mem_req     (s_cur.mem_req),
        .i_dmem_ready  (s_cur.dmem_ready),
        .o_pc_en       (o_pc_en),
        .o_if_id_en    (o_if_id_en),
        .o_id_ex_en    (o_id_ex_en),
        .o_ex_mem_en   (o_ex_mem_en),
        .o_mem_wb_en   (o_mem_wb_en),
        .o_if_id_flush (o_if_id_flush),
        .o_id_ex_flush (o_id_ex_flush),
        .o_halt        (o_halt),
        .o_err         (o_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt)
`endif
    );

    // Reference model: halted flag, cause, cycles waited on memory, bubbles issued for an illegal insn.
    bit          m_halt;
    logic [1:0]  m_err;
    int          m_wait;
    int          m_drain;
    logic [31:0] m_sc, m_fc;
    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    function automatic stim_t idle();
        stim_t s;
        s             = '0;
        s.rst_n       = 1'b1;
        s.id_valid    = 1'b1;
        s.id_insn_vld = 1'b1;
        s.dmem_ready  = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        logic [6:0] ef;   // pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush
        exp_t e;
        bit luh, mw, illegal;
        @(posedge clk);
        #1;
        s_cur = s;
        cyc++;
        luh = s.ex_is_load && s.ex_rd_wren && (s.ex_rd != 5'd0) &&
              ((s.rs1_used && s.rs1 == s.ex_rd) || (s.rs2_used && s.rs2 == s.ex_rd));
        mw      = s.mem_req && !s.dmem_ready;
        illegal = s.id_valid && !s.id_insn_vld;
        ef = 7'b0;
        if (!s.rst_n) begin
            m_halt = 0; m_err = 2'b00; m_wait = 0; m_drain = 0; m_sc = 0; m_fc = 0;
            e.v = 10'b0; e.sc = 0; e.fc = 0;
        end else begin
            e.v  = {7'b0, m_halt, m_err};
            e.sc = m_sc;
            e.fc = m_fc;
            if (m_halt) begin
                ef = 7'b0;
            end else if (m_drain > 0) begin
                ef = {2'b00, !mw, !mw, !mw, 1'b0, 1'b1};
                if (!mw) begin
                    m_drain++;
                    if (m_drain >= DRAIN) begin m_halt = 1; m_err = 2'b01; m_drain = 0; end
                end
            end else if (m_wait > 0) begin
                if (s.dmem_ready) begin
                    ef = 7'b1111100; m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= MEM_TO) begin m_halt = 1; m_err = 2'b10; m_wait = 0; end
                end
            end else if (mw) begin
                m_wait = 1;
            end else if (s.ex_redirect) begin
                ef = 7'b1111111;
            end else if (illegal) begin
                ef = 7'b0011101; m_drain = 1;
            end else if (luh) begin
                ef = 7'b0011101;
            end else begin
                ef = 7'b1111100;
            end
            e.v[9:3] = ef;
            if (!e.v[2] && !ef[6] && m_sc != 32'hFFFF_FFFF) m_sc++;
            if (ef[1] && m_fc != 32'hFFFF_FFFF) m_fc++;
        end
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [9:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
                   o_if_id_flush, o_id_ex_flush, o_halt, o_err};
            n_tests++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL outputs cyc%0d got %b want %b (pc,ifid,idex,exmem,memwb,iff,idf,halt,err)",
                         e.cyc, got, e.v);
            end
`ifdef HAZARD_PERF_CNT_EN
            n_tests++;
            if (o_stall_cnt !== e.sc || o_flush_cnt !== e.fc) begin
                n_fail++;
                $display("FAIL perf_cnt cyc%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         e.cyc, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
            end
`endif
        end
    end

    initial begin
        stim_t s;
        s_cur = idle();
        s_cur.rst_n = 1'b0;
        m_halt = 0; m_err = 0; m_wait = 0; m_drain = 0; m_sc = 0; m_fc = 0;

        s = idle(); s.rst_n = 1'b0;
        repeat (2) apply(s);

        // Load-use on rs1, then EX holds the bubble
        s = idle(); s.ex_is_load = 1; s.ex_rd_wren = 1; s.ex_rd = 5'd5;
        s.rs1 = 5'd5; s.rs1_used = 1; s.rs2 = 5'd7; s.rs2_used = 1;
        apply(s);
        apply(idle());
        // x0 destination and unused operands never stall
        s.ex_rd = 5'd0; s.rs1 = 5'd0; apply(s);
        s.ex_rd = 5'd5; s.rs1 = 5'd5; s.rs1_used = 0; apply(s);
        // rs2 match
        s.rs2 = 5'd5; s.rs2_used = 1; apply(s);
        // Redirect overrides load-use
        s.ex_redirect = 1; apply(s);
        apply(idle());

        // Memory wait 4 cycles then ready
        s = idle(); s.mem_req = 1; s.dmem_ready = 0;
        repeat (4) apply(s);
        s.dmem_ready = 1; apply(s);
        apply(idle());
        // Ready arrives on the 16th wait cycle: success
        s.dmem_ready = 0;
        repeat (15) apply(s);
        s.dmem_ready = 1; s.ex_redirect = 1; apply(s);
        apply(s);
        // Reset in MEM_WAIT
        s = idle(); s.mem_req = 1; s.dmem_ready = 0;
        repeat (3) apply(s);
        s.rst_n = 0; apply(s);
        apply(idle());
        // Timeout after 16 low cycles
        s = idle(); s.mem_req = 1; s.dmem_ready = 0;
        repeat (MEM_TO + 2) apply(s);
        apply(idle());
        // Reset in HALT, then back to RUN
        s = idle(); s.rst_n = 0; apply(s);
        apply(idle());

        // Illegal instruction: drain with a redirect and a memory freeze, then halt
        s = idle(); s.id_insn_vld = 0; apply(s);
        s.ex_redirect = 1; apply(s);
        s.mem_req = 1; s.dmem_ready = 0; apply(s);
        s.dmem_ready = 1; apply(s);
        repeat (3) apply(s);
        s = idle(); s.rst_n = 0; apply(s);

        // Randomized traffic with occasional long memory stalls and resets
        for (int blk = 0; blk < 40; blk++) begin
            for (int i = 0; i < 60; i++) begin
                s = idle();
                s.id_valid    = ($urandom_range(0, 7) != 0);
                s.id_insn_vld = ($urandom_range(0, 39) != 0);
                s.rs1         = 5'($urandom_range(0, 3));
                s.rs2         = 5'($urandom_range(0, 3));
                s.rs1_used    = 1'($urandom_range(0, 1));
                s.rs2_used    = 1'($urandom_range(0, 1));
                s.ex_rd       = 5'($urandom_range(0, 3));
                s.ex_rd_wren  = 1'($urandom_range(0, 1));
                s.ex_is_load  = 1'($urandom_range(0, 1));
                s.ex_redirect = ($urandom_range(0, 5) == 0);
                s.mem_req     = ($urandom_range(0, 2) == 0);
                s.dmem_ready  = ($urandom_range(0, 3) != 0);
                s.rst_n       = ($urandom_range(0, 199) != 0) &&
                                !(m_halt && $urandom_range(0, 3) == 0);
                apply(s);
            end
            if ($urandom_range(0, 1) == 1) begin
                s = idle(); s.mem_req = 1; s.dmem_ready = 0;
                repeat ($urandom_range(12, 18)) apply(s);
            end
        end

        @(posedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
